// File: rtl/dmem_pkg.sv
// Shared types and sizes for the data-memory arbiter slice.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 8;
    localparam int unsigned DMEM_DATA_W = 16;

    typedef enum logic [1:0] {ARB, LOCK_CORE, LOCK_DBG} arb_state_t;
    typedef enum logic {REQ_CORE, REQ_DBG} req_id_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the side not granted last wins.
module rr_pick2
    import dmem_pkg::*;
(
    input  logic    core_valid,
    input  logic    dbg_valid,
    input  req_id_t rr_last,
    output logic    grant_valid,
    output req_id_t grant
);

    always_comb begin
        grant_valid = core_valid | dbg_valid;
        if (core_valid && dbg_valid) begin
            grant = (rr_last == REQ_CORE) ? REQ_DBG : REQ_CORE;
        end else if (dbg_valid) begin
            grant = REQ_DBG;
        end else begin
            grant = REQ_CORE;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core load/store path and the debug/DMA port,
// with round-robin grant, bounded bus lock and per-requester read-response steering.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W   = DMEM_DATA_W,
    parameter int unsigned ADDR_W   = DMEM_ADDR_W,
    parameter int unsigned LOCK_MAX = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_valid,
    output logic              core_ready,
    input  logic              core_we,
    input  logic              core_lock,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_rsp_valid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_rsp_valid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned      CNT_W    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_t       state;
    req_id_t          rr_last;
    logic [CNT_W-1:0] lock_cnt;
    logic             pick_valid;
    req_id_t          pick_id;
    logic             core_acc;
    logic             dbg_acc;
    logic             rsp_core_q;
    logic             rsp_dbg_q;

    rr_pick2 u_pick (
        .core_valid  (core_valid),
        .dbg_valid   (dbg_valid),
        .rr_last     (rr_last),
        .grant_valid (pick_valid),
        .grant       (pick_id)
    );

    always_comb begin
        core_ready = 1'b0;
        dbg_ready  = 1'b0;
        if (!reset) begin
            case (state)
                ARB: begin
                    core_ready = pick_valid && (pick_id == REQ_CORE);
                    dbg_ready  = pick_valid && (pick_id == REQ_DBG);
                end
                LOCK_CORE: core_ready = core_valid;
                LOCK_DBG:  dbg_ready  = dbg_valid;
                default:   ;
            endcase
        end
    end

    assign core_acc = core_valid & core_ready;
    assign dbg_acc  = dbg_valid & dbg_ready;

    always_comb begin
        mem_en    = core_acc | dbg_acc;
        mem_we    = dbg_acc ? dbg_we    : core_we;
        mem_addr  = dbg_acc ? dbg_addr  : core_addr;
        mem_wdata = dbg_acc ? dbg_wdata : core_wdata;
    end

    // While locked, ready == valid for the owner, so "accepted with lock=0" and
    // "idle with lock=0" both collapse to the owner's lock bit being low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB;
            rr_last    <= REQ_DBG;
            lock_cnt   <= '0;
            rsp_core_q <= 1'b0;
            rsp_dbg_q  <= 1'b0;
        end else begin
            rsp_core_q <= core_acc & ~core_we;
            rsp_dbg_q  <= dbg_acc & ~dbg_we;
            case (state)
                ARB: begin
                    lock_cnt <= '0;
                    if (core_acc) begin
                        rr_last <= REQ_CORE;
                        if (core_lock) state <= LOCK_CORE;
                    end else if (dbg_acc) begin
                        rr_last <= REQ_DBG;
                        if (dbg_lock) state <= LOCK_DBG;
                    end
                end
                LOCK_CORE: begin
                    lock_cnt <= lock_cnt + 1'b1;
                    if (core_acc) rr_last <= REQ_CORE;
                    if (lock_cnt == CNT_LAST) begin
                        state   <= ARB;
                        rr_last <= REQ_CORE;
                    end else if (!core_lock) begin
                        state <= ARB;
                    end
                end
                LOCK_DBG: begin
                    lock_cnt <= lock_cnt + 1'b1;
                    if (dbg_acc) rr_last <= REQ_DBG;
                    if (lock_cnt == CNT_LAST) begin
                        state   <= ARB;
                        rr_last <= REQ_DBG;
                    end else if (!dbg_lock) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // A response pending across a reset cycle is suppressed, not delivered late.
    assign core_rsp_valid = rsp_core_q & ~reset;
    assign dbg_rsp_valid  = rsp_dbg_q & ~reset;
    assign core_rdata     = mem_rdata;
    assign dbg_rdata      = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter, checked against a behavioural
// model of grant order, lock budget and memory contents.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;
    localparam int          LM = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_valid, core_ready, core_we, core_lock, core_rsp_valid;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          dbg_valid, dbg_ready, dbg_we, dbg_lock, dbg_rsp_valid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LOCK_MAX(LM)) dut (
        .clk(clk), .reset(reset),
        .core_valid(core_valid), .core_ready(core_ready), .core_we(core_we),
        .core_lock(core_lock), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rsp_valid(core_rsp_valid), .core_rdata(core_rdata),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
        .dbg_lock(dbg_lock), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // The memory the arbiter fronts.
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: owner -1 = free, 0 = core, 1 = dbg; left = lock cycles remaining.
    int            owner = -1;
    int            left = 0;
    int            last = 1;
    int            last_grant = -1;
    logic [DW-1:0] gold [256];
    bit            known [256];
    bit            exp_core_rsp = 0, exp_dbg_rsp = 0, exp_known = 0;
    logic [DW-1:0] exp_data = '0;
    logic          obs_core_ready;
    int            core_grants = 0;
    int            streak = 0, max_streak = 0;

    function automatic int model_grant();
        if (owner < 0) begin
            if (core_valid && dbg_valid) return (last == 0) ? 1 : 0;
            if (core_valid) return 0;
            if (dbg_valid) return 1;
            return -1;
        end
        if (owner == 0) return core_valid ? 0 : -1;
        return dbg_valid ? 1 : -1;
    endfunction

    task automatic step();
        int            g;
        logic          we, olock, ovalid;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        #1;
        if (reset) begin
            exp_core_rsp = 0;
            exp_dbg_rsp  = 0;
        end
        check("core_rsp_valid", core_rsp_valid, exp_core_rsp);
        check("dbg_rsp_valid", dbg_rsp_valid, exp_dbg_rsp);
        if (exp_core_rsp && exp_known) check("core_rdata", core_rdata, exp_data);
        if (exp_dbg_rsp && exp_known) check("dbg_rdata", dbg_rdata, exp_data);

        g = reset ? -1 : model_grant();
        obs_core_ready = core_ready;
        check("core_ready", core_ready, g == 0);
        check("dbg_ready", dbg_ready, g == 1);
        check("mem_en", mem_en, g >= 0);
        if (g == 0) begin
            check("mem_we", mem_we, core_we);
            check("mem_addr", mem_addr, core_addr);
            if (core_we) check("mem_wdata", mem_wdata, core_wdata);
        end
        if (g == 1) begin
            check("mem_we", mem_we, dbg_we);
            check("mem_addr", mem_addr, dbg_addr);
            if (dbg_we) check("mem_wdata", mem_wdata, dbg_wdata);
        end
        if (core_valid && core_ready) core_grants++;
        if (!reset && core_valid && !core_ready) streak++;
        else streak = 0;
        if (streak > max_streak) max_streak = streak;

        exp_core_rsp = 0;
        exp_dbg_rsp  = 0;
        if (reset) begin
            owner = -1;
            left  = 0;
            last  = 1;
        end else begin
            if (g >= 0) begin
                we = (g == 0) ? core_we : dbg_we;
                a  = (g == 0) ? core_addr : dbg_addr;
                wd = (g == 0) ? core_wdata : dbg_wdata;
                if (we) begin
                    gold[a]  = wd;
                    known[a] = 1;
                end else begin
                    exp_data     = gold[a];
                    exp_known    = known[a];
                    exp_core_rsp = (g == 0);
                    exp_dbg_rsp  = (g == 1);
                end
                last = g;
            end
            if (owner < 0) begin
                if ((g == 0 && core_lock) || (g == 1 && dbg_lock)) begin
                    owner = g;
                    left  = LM;
                end
            end else begin
                left--;
                olock  = (owner == 0) ? core_lock : dbg_lock;
                ovalid = (owner == 0) ? core_valid : dbg_valid;
                if (left == 0) begin
                    last  = owner;
                    owner = -1;
                end else if ((g == owner && !olock) || (!ovalid && !olock)) begin
                    owner = -1;
                end
            end
        end
        last_grant = g;
        @(negedge clk);
    endtask

    task automatic drive_core(input logic v, input logic we, input logic lk,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_valid = v; core_we = we; core_lock = lk; core_addr = a; core_wdata = d;
    endtask

    task automatic drive_dbg(input logic v, input logic we, input logic lk,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        dbg_valid = v; dbg_we = we; dbg_lock = lk; dbg_addr = a; dbg_wdata = d;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int who, input string tag);
        for (int i = 0; i < LM + 8; i++) begin
            step();
            if (last_grant == who) return;
        end
        check(tag, last_grant, who);
    endtask

    function automatic logic pick(input int m);
        return (m == 2) ? 1'($urandom_range(1)) : (m == 1);
    endfunction

    // Random traffic; a request keeps its payload until it is accepted.
    task automatic run(input int n, input int pc, input int pd, input int lk);
        for (int i = 0; i < n; i++) begin
            if (!core_valid || last_grant == 0)
                drive_core(($urandom_range(99) < pc), pick(2), pick(lk),
                           8'($urandom_range(15)), 16'($urandom));
            if (!dbg_valid || last_grant == 1)
                drive_dbg(($urandom_range(99) < pd), pick(2), pick(lk),
                          8'($urandom_range(15)), 16'($urandom));
            step();
        end
    endtask

    int snap;

    initial begin
        reset = 1'b1;
        drive_core(1, 0, 0, '0, '0);
        drive_dbg(1, 1, 0, '0, '0);
        do_reset(3);

        // Preload 0xBEEF at 0x10, then core reads it back.
        drive_core(0, 0, 0, '0, '0);
        drive_dbg(1, 1, 0, 8'h10, 16'hBEEF);
        step();
        drive_dbg(0, 0, 0, '0, '0);
        drive_core(1, 0, 0, 8'h10, '0);
        step();
        check("beef_rsp_valid", core_rsp_valid, 1);
        check("beef_rdata", core_rdata, 16'hBEEF);
        check("beef_dbg_quiet", dbg_rsp_valid, 0);
        drive_core(0, 0, 0, '0, '0);
        step();

        // Tie every cycle without lock: strict alternation, core first after reset.
        do_reset(1);
        drive_core(1, 1, 0, 8'h30, 16'hA5A5);
        drive_dbg(1, 0, 0, 8'h10, '0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("alternate", obs_core_ready, (i % 2) == 0);
        end

        // Locked 16-beat debug burst while core stays valid.
        do_reset(1);
        drive_core(1, 0, 0, 8'h03, '0);
        snap = 0;
        for (int i = 0; i < 16; i++) begin
            drive_dbg(1, 1, (i < 15), 8'(i), 16'(i));
            wait_grant(1, "burst_wait");
            if (i == 0) snap = core_grants;
        end
        check("burst_core_blocked", core_grants - snap, 0);
        drive_dbg(0, 0, 0, '0, '0);
        step();
        check("burst_release", obs_core_ready, 1);

        // Read-after-write and write-after-read on 0x20.
        drive_core(0, 0, 0, '0, '0);
        drive_dbg(1, 1, 0, 8'h20, 16'h1234);
        step();
        drive_dbg(0, 0, 0, '0, '0);
        drive_core(1, 0, 0, 8'h20, '0);
        step();
        check("raw_rdata", core_rdata, 16'h1234);
        drive_core(0, 0, 0, '0, '0);
        drive_dbg(1, 1, 0, 8'h20, 16'h5555);
        step();
        drive_dbg(0, 0, 0, '0, '0);
        drive_core(1, 0, 0, 8'h20, '0);
        step();
        check("war_rdata", core_rdata, 16'h5555);

        // Read in flight when reset hits: response dropped, then core wins the tie.
        drive_core(1, 0, 0, 8'h10, '0);
        step();
        drive_core(0, 0, 0, '0, '0);
        do_reset(2);
        check("rif_no_rsp", core_rsp_valid, 0);
        drive_core(1, 0, 0, 8'h10, '0);
        drive_dbg(1, 0, 0, 8'h10, '0);
        step();
        check("tie_after_reset", obs_core_ready, 1);

        // Debug holds a lock forever: core waits at most LOCK_MAX + 1 cycles.
        do_reset(1);
        max_streak = 0;
        for (int i = 0; i < 200; i++) begin
            drive_core(1, 0, 0, 8'h05, '0);
            drive_dbg(1, 1, 1, 8'(i % 16), 16'(i));
            step();
        end
        check("lock_max_wait", max_streak, LM + 1);

        // Random traffic with occasional locks.
        do_reset(1);
        run(500, 70, 70, 2);
        run(300, 95, 95, 0);
        run(300, 50, 90, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single data-memory port (`data_mem`, 256 x 16) between the processor core's load/store path and the debug/DMA port used to preload and dump memory. Round-robin grant with an optional bus lock for multi-word bursts and a lock-timeout counter. Read data returns one cycle after acceptance and is steered back to the requester that issued it. Sits between `z8ProcessorCore`'s memory stage and `mem`.

## Interface
- `DATA_W`, 16, data word width
- `ADDR_W`, 8, word address width (256 words)
- `LOCK_MAX`, 64, maximum consecutive cycles one requester may hold a lock

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `core_valid`, `core_ready`  in/out  1  core request handshake
- `core_we`  in  1  1 = write, 0 = read
- `core_lock`  in  1  request lock after this beat
- `core_addr`  in  ADDR_W  word address
- `core_wdata`  in  DATA_W  write data
- `core_rsp_valid`  out  1  read data valid
- `core_rdata`  out  DATA_W  read data
- `dbg_*`  same set as `core_*`  debug/DMA requester
- `mem_en`, `mem_we`  out  1  memory strobe, write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_en & !mem_we`

## Operation
- A beat is accepted when `x_valid & x_ready`. `x_ready` is combinational from the valids and the state. At most one requester is ready per cycle.
- On acceptance, `mem_en = 1` and `mem_we/addr/wdata` are taken from the granted requester in the same cycle. When nothing is accepted, `mem_en = 0` and the other memory outputs are don't-care.
- State machine `ARB`, `LOCK_CORE`, `LOCK_DBG`:
  - **ARB:**
    - One valid requester gets the grant.
    - If both are valid, the requester not granted most recently wins. `rr_last` updates on every acceptance.
    - An accepted beat with `lock = 1` moves the FSM to `LOCK_<winner>` and clears `lock_cnt`.
  - **LOCK_x:**
    - Only x may be granted.
    - An accepted beat with `lock = 0` returns the FSM to ARB.
    - A cycle with `x_valid = 0 & x_lock = 0` also returns the FSM to ARB.
    - `lock_cnt` increments every cycle. When `lock_cnt` reaches `LOCK_MAX - 1`, that cycle may still grant x, and the FSM is then forced to ARB with `rr_last = x` regardless of `x_lock`.
- Read response:
  - A registered tag records which requester's read was accepted.
  - Next cycle, that requester's `rsp_valid = 1` and `rdata = mem_rdata`. The other requester's `rsp_valid` stays 0.
  - Writes produce no response.
  - Back-to-back reads give back-to-back responses with no bubble.
- `core_rdata` and `dbg_rdata` are don't-care when the matching `rsp_valid = 0`. The bench checks them only under `rsp_valid`.
- Read followed by a write to the same address: the read returns the old data.

## Timing
- Reset (synchronous) sets:
  - state = ARB
  - `rr_last` = DBG, so core wins the first tie
  - `lock_cnt` = 0
  - `core_rsp_valid`, `dbg_rsp_valid` = 0
- With no valid inputs during reset, `core_ready`, `dbg_ready` and `mem_en` are 0.
- While `reset = 1`, both `ready` signals are forced to 0 and `mem_en = 0`.
- Reset mid-burst or with a read in flight: the lock is dropped and the pending response is discarded, so no `rsp_valid` appears in the cycle after reset.
- Grant latency is 0 cycles when the resource is free. Read latency is 1 cycle from acceptance to `rsp_valid`.
- Requesters must hold `valid` and payload stable until `ready` is seen. The arbiter may deny a valid request indefinitely only while the other side holds a lock, which is bounded by `LOCK_MAX`.
- Worst-case wait for an unlocked requester is `LOCK_MAX + 1` cycles.

## Structure
- Add to shared package `instruction_set`, or a new `dmem_pkg` if the team prefers to keep the ISA package pure:
  - `typedef enum logic [1:0] {ARB, LOCK_CORE, LOCK_DBG} arb_state_t`
  - `typedef enum logic {REQ_CORE, REQ_DBG} req_id_t`
  - `DMEM_ADDR_W` and `DMEM_DATA_W` constants
- One natural sub-module: `rr_pick2`, the combinational two-way round-robin picker (valids, `rr_last` -> grant id). The FSM, lock counter and response tag stay in `dmem_arbiter`.

## Test plan
- Reset, then core reads addr 0x10 holding 0xBEEF -> `core_ready = 1` in the same cycle, `core_rsp_valid = 1` with 0xBEEF one cycle later, `dbg_rsp_valid` stays 0.
- Both valid every cycle, core writes and debug reads, no lock -> grants alternate core, dbg, core, dbg, with core first after reset. Each debug read response lands on `dbg` only.
- Debug writes 0x0000..0x000F to addrs 0x00-0x0F with `dbg_lock = 1` on the first 15 beats, while core is continuously valid -> `core_ready = 0` for all 16 beats. Core is granted on the cycle after the lock=0 beat.
- Debug holds `dbg_lock = 1` and valid for 100 cycles with `LOCK_MAX` = 64, core valid -> core granted exactly at cycle 65, after which ARB resumes alternating.
- Core read accepted, reset asserted the next cycle -> `core_rsp_valid = 0` throughout; after reset the state is ARB and a core/dbg tie grants core.
- Debug writes 0x1234 to addr 0x20 and core reads 0x20 in the following cycle -> core receives 0x1234. A read accepted in the same cycle as a prior write to the same address returns the old value.
